code_mem_arbiter: RTL and testbench

Shares the single external code-memory read port between NUM_REQ instruction-fetch requesters, for example per-SM fetch units in a multi-SM top. It uses round-robin arbitration and keeps exactly one read outstanding at a time. Each returned word is routed back to the requester that issued it. The block sits between the sm_core fetch ports and the top-level code_read_* pins.

---
 rtl/code_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/code_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_code_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/code_arb_pkg.sv
// Shared types and helpers for the code-memory arbiter.
// Default widths apply only when common/define.sv has not already set them.
`ifndef CODE_MEM_ADDR_WIDTH
`define CODE_MEM_ADDR_WIDTH 16
`endif
`ifndef CODE_MEM_DATA_WIDTH
`define CODE_MEM_DATA_WIDTH 32
`endif

package code_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int NUM_REQ_DEF = 4;

  function automatic int req_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REQ_ID_W = req_id_w(NUM_REQ_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first active request at or after ptr_i wins.
// Kept free of state so the same picker can serve other dispatch points.
module rr_arbiter
  import code_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = req_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     idx_o
);

  logic [IDW:0] cand;
  logic         found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // ptr_i < NUM_REQ, so a single subtraction wraps the sum.
      cand = {1'b0, ptr_i} + (IDW+1)'(off);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!found && req_i[cand[IDW-1:0]]) begin
        found                 = 1'b1;
        gnt_o[cand[IDW-1:0]]  = 1'b1;
        idx_o                 = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/code_mem_arbiter.sv
// Round-robin arbiter sharing the code-memory read port, one read outstanding.
// CODE_ARB_TIMEOUT_EN adds a WAIT watchdog, rsp_err_o and stale-response discard.
//
// state | meaning
// IDLE  | pick a requester, accept its address
// ISSUE | drive read command until memory takes it
// WAIT  | wait for read data, route it to the owner
module code_mem_arbiter
  import code_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = `CODE_MEM_ADDR_WIDTH,
  parameter int DATA_W  = `CODE_MEM_DATA_WIDTH
`ifdef CODE_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
`ifdef CODE_ARB_TIMEOUT_EN
  output logic                      rsp_err_o,
`endif
  input  logic                      code_mem_available_i,
  output logic                      code_read_valid_o,
  output logic [ADDR_W-1:0]         code_read_addr_o,
  input  logic                      code_read_ready_i,
  input  logic [DATA_W-1:0]         code_read_data_i
);

  localparam int IDW = req_id_w(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d, owner_q, owner_d, win_idx;
  logic [ADDR_W-1:0]   addr_q, addr_d, win_addr;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d, win_gnt, owner_oh;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
`ifdef CODE_ARB_TIMEOUT_EN
  localparam int TMO_W = req_id_w(TIMEOUT_CYCLES);
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [3:0]          stale_q, stale_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  always_comb begin
    win_addr = '0;
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_gnt[i]) win_addr = req_addr_i[i*ADDR_W +: ADDR_W];
      if (owner_q == IDW'(i)) owner_oh[i] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
`ifdef CODE_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
    stale_d     = stale_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          addr_d   = win_addr;
          owner_d  = win_idx;
          rr_ptr_d = (win_idx == IDW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (code_mem_available_i) begin
          state_d = WAIT;
`ifdef CODE_ARB_TIMEOUT_EN
          tmo_d   = TMO_W'(TIMEOUT_CYCLES-1);
`endif
        end
      end
      WAIT: begin
`ifdef CODE_ARB_TIMEOUT_EN
        // Memory answers in order, so a pending stale count owns the next data beat.
        if (code_read_ready_i && stale_q != 4'd0) begin
          stale_d = stale_q - 4'd1;
        end else if (code_read_ready_i) begin
          rsp_valid_d = owner_oh;
          rsp_data_d  = code_read_data_i;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end else if (tmo_q == '0) begin
          rsp_valid_d = owner_oh;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          stale_d     = (stale_q == 4'hF) ? stale_q : stale_q + 4'd1;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
`else
        if (code_read_ready_i) begin
          rsp_valid_d = owner_oh;
          rsp_data_d  = code_read_data_i;
          state_d     = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef CODE_ARB_TIMEOUT_EN
    if (state_q != WAIT && code_read_ready_i && stale_q != 4'd0) stale_d = stale_q - 4'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifdef CODE_ARB_TIMEOUT_EN
      tmo_q       <= '0;
      stale_q     <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef CODE_ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
      stale_q     <= stale_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign req_ready_o       = (state_q == IDLE && rst_n) ? win_gnt : '0;
  assign code_read_valid_o = (state_q == ISSUE);
  assign code_read_addr_o  = addr_q;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_data_o        = rsp_data_q;
`ifdef CODE_ARB_TIMEOUT_EN
  assign rsp_err_o         = rsp_err_q;
`endif

endmodule

// File: tb/tb_code_mem_arbiter.sv
// Directed bench for code_mem_arbiter; table rows plus reset and timeout sequences.
// Timeout sequence is built only with CODE_ARB_TIMEOUT_EN defined.
`timescale 1ns/1ps
`ifndef CODE_MEM_ADDR_WIDTH
`define CODE_MEM_ADDR_WIDTH 16
`endif
`ifndef CODE_MEM_DATA_WIDTH
`define CODE_MEM_DATA_WIDTH 32
`endif
module tb_code_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = `CODE_MEM_ADDR_WIDTH;
  localparam int DW = `CODE_MEM_DATA_WIDTH;
`ifdef CODE_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`endif

  localparam logic [AW-1:0] A0 = AW'(16'h0040);
  localparam logic [AW-1:0] A1 = AW'(16'h0081);
  localparam logic [AW-1:0] A2 = AW'(16'h00C2);
  localparam logic [AW-1:0] A3 = AW'(16'h0103);

  logic            clk, rst_n;
  logic [N-1:0]    req_valid_i, req_ready_o, rsp_valid_o;
  logic [N*AW-1:0] req_addr_i;
  logic [DW-1:0]   rsp_data_o, code_read_data_i;
  logic            code_mem_available_i, code_read_valid_o, code_read_ready_i;
  logic [AW-1:0]   code_read_addr_o;
`ifdef CODE_ARB_TIMEOUT_EN
  logic            rsp_err_o;
`endif

  code_mem_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)
`ifdef CODE_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid_i          (req_valid_i),
    .req_addr_i           (req_addr_i),
    .req_ready_o          (req_ready_o),
    .rsp_valid_o          (rsp_valid_o),
    .rsp_data_o           (rsp_data_o),
`ifdef CODE_ARB_TIMEOUT_EN
    .rsp_err_o            (rsp_err_o),
`endif
    .code_mem_available_i (code_mem_available_i),
    .code_read_valid_o    (code_read_valid_o),
    .code_read_addr_o     (code_read_addr_o),
    .code_read_ready_i    (code_read_ready_i),
    .code_read_data_i     (code_read_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  req;
    logic          avail;
    logic          rdy;
    logic [DW-1:0] rdata;
    logic [N-1:0]  e_ready;
    logic          e_crv;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_rsp;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [N-1:0] req, input logic avail, input logic rdy,
                     input logic [DW-1:0] rdata, input logic [N-1:0] e_ready,
                     input logic e_crv, input logic [AW-1:0] e_addr,
                     input logic [N-1:0] e_rsp, input logic [DW-1:0] e_data);
    vec_t v;
    v.req = req; v.avail = avail; v.rdy = rdy; v.rdata = rdata;
    v.e_ready = e_ready; v.e_crv = e_crv; v.e_addr = e_addr;
    v.e_rsp = e_rsp; v.e_data = e_data;
    vecs.push_back(v);
  endtask

  // Drive a row at the falling edge, check 1ns later (comb and last-edge registered outputs).
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    req_valid_i          = v.req;
    code_mem_available_i = v.avail;
    code_read_ready_i    = v.rdy;
    code_read_data_i     = v.rdata;
    #1;
    chk($sformatf("row%0d req_ready", idx), 64'(req_ready_o), 64'(v.e_ready));
    chk($sformatf("row%0d code_read_valid", idx), 64'(code_read_valid_o), 64'(v.e_crv));
    if (v.e_crv) chk($sformatf("row%0d code_read_addr", idx), 64'(code_read_addr_o), 64'(v.e_addr));
    chk($sformatf("row%0d rsp_valid", idx), 64'(rsp_valid_o), 64'(v.e_rsp));
    if (v.e_rsp != '0) begin
      chk($sformatf("row%0d rsp_data", idx), 64'(rsp_data_o), 64'(v.e_data));
`ifdef CODE_ARB_TIMEOUT_EN
      chk($sformatf("row%0d rsp_err", idx), 64'(rsp_err_o), 64'(0));
`endif
    end
  endtask

  task automatic row(input logic [N-1:0] req, input logic avail, input logic rdy,
                     input logic [DW-1:0] rdata, input logic [N-1:0] e_ready,
                     input logic e_crv, input logic [AW-1:0] e_addr,
                     input logic [N-1:0] e_rsp, input logic [DW-1:0] e_data, input int idx);
    vec_t v;
    v.req = req; v.avail = avail; v.rdy = rdy; v.rdata = rdata;
    v.e_ready = e_ready; v.e_crv = e_crv; v.e_addr = e_addr;
    v.e_rsp = e_rsp; v.e_data = e_data;
    apply(v, idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid_i = 4'b1111;
    req_addr_i = {A3, A2, A1, A0};
    code_mem_available_i = 1'b1;
    code_read_ready_i = 1'b0;
    code_read_data_i = '0;

    // Round robin with everyone requesting: grants 0,1,2,3,0.
    add(4'b1111,1,0,0,            4'b0001,0,'0,4'b0000,0);
    add(4'b1111,1,0,0,            4'b0000,1,A0,4'b0000,0);
    add(4'b1111,1,1,32'hA0000000, 4'b0000,0,'0,4'b0000,0);
    add(4'b1111,1,0,0,            4'b0010,0,'0,4'b0001,32'hA0000000);
    add(4'b1111,1,0,0,            4'b0000,1,A1,4'b0000,0);
    add(4'b1111,1,1,32'hA0000001, 4'b0000,0,'0,4'b0000,0);
    add(4'b1111,1,0,0,            4'b0100,0,'0,4'b0010,32'hA0000001);
    add(4'b1111,1,0,0,            4'b0000,1,A2,4'b0000,0);
    add(4'b1111,1,1,32'hA0000002, 4'b0000,0,'0,4'b0000,0);
    add(4'b1111,1,0,0,            4'b1000,0,'0,4'b0100,32'hA0000002);
    add(4'b1111,1,0,0,            4'b0000,1,A3,4'b0000,0);
    add(4'b1111,1,1,32'hA0000003, 4'b0000,0,'0,4'b0000,0);
    add(4'b1111,1,0,0,            4'b0001,0,'0,4'b1000,32'hA0000003);
    add(4'b1111,1,0,0,            4'b0000,1,A0,4'b0000,0);
    add(4'b1111,1,1,32'hA0000004, 4'b0000,0,'0,4'b0000,0);
    add(4'b0000,1,0,0,            4'b0000,0,'0,4'b0001,32'hA0000004);
    // Single request from requester 0: accept T, command T+1, response T+3.
    add(4'b0001,1,0,0,            4'b0001,0,'0,4'b0000,0);
    add(4'b0000,1,0,0,            4'b0000,1,A0,4'b0000,0);
    add(4'b0000,1,1,32'hDEADBEEF, 4'b0000,0,'0,4'b0000,0);
    add(4'b0000,1,0,0,            4'b0000,0,'0,4'b0001,32'hDEADBEEF);
    // Memory unavailable for 5 cycles: command held 6 cycles, taken once.
    add(4'b0100,0,0,0,            4'b0100,0,'0,4'b0000,0);
    for (int i = 0; i < 5; i++) add(4'b0000,0,0,0, 4'b0000,1,A2,4'b0000,0);
    add(4'b0000,1,0,0,            4'b0000,1,A2,4'b0000,0);
    add(4'b0000,1,0,0,            4'b0000,0,'0,4'b0000,0);
    add(4'b0000,1,1,32'hCAFE0002, 4'b0000,0,'0,4'b0000,0);
    add(4'b0000,0,0,0,            4'b0000,0,'0,4'b0100,32'hCAFE0002);
    // Stray read-ready in IDLE and ISSUE is ignored.
    add(4'b0000,0,1,32'hBAD0BAD0, 4'b0000,0,'0,4'b0000,0);
    add(4'b0000,0,1,32'hBAD0BAD1, 4'b0000,0,'0,4'b0000,0);
    add(4'b1000,0,0,0,            4'b1000,0,'0,4'b0000,0);
    add(4'b0000,0,1,32'hBAD0BAD2, 4'b0000,1,A3,4'b0000,0);
    add(4'b0000,1,0,0,            4'b0000,1,A3,4'b0000,0);
    add(4'b0000,1,1,32'h33333333, 4'b0000,0,'0,4'b0000,0);
    add(4'b0000,0,0,0,            4'b0000,0,'0,4'b1000,32'h33333333);

    // Reset state, with every requester asking.
    #3;
    chk("reset req_ready", 64'(req_ready_o), 64'(0));
    chk("reset code_read_valid", 64'(code_read_valid_o), 64'(0));
    chk("reset code_read_addr", 64'(code_read_addr_o), 64'(0));
    chk("reset rsp_valid", 64'(rsp_valid_o), 64'(0));
    chk("reset rsp_data", 64'(rsp_data_o), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_valid_i = '0;

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset in WAIT with the pointer at 2: outputs clear at once, priority back to 0.
    row(4'b0010,1,0,0, 4'b0010,0,'0,4'b0000,0, 100);
    row(4'b0000,1,0,0, 4'b0000,1,A1,4'b0000,0, 101);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid_i = 4'b1111;
    code_read_ready_i = 1'b1;
    code_read_data_i = 32'h55555555;
    #1;
    chk("midreset req_ready", 64'(req_ready_o), 64'(0));
    chk("midreset code_read_valid", 64'(code_read_valid_o), 64'(0));
    chk("midreset code_read_addr", 64'(code_read_addr_o), 64'(0));
    chk("midreset rsp_valid", 64'(rsp_valid_o), 64'(0));
    chk("midreset rsp_data", 64'(rsp_data_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    req_valid_i = '0;
    code_read_ready_i = 1'b0;
    row(4'b1111,1,0,0,            4'b0001,0,'0,4'b0000,0, 102);
    row(4'b0000,1,0,0,            4'b0000,1,A0,4'b0000,0, 103);
    row(4'b0000,1,1,32'h77777777, 4'b0000,0,'0,4'b0000,0, 104);
    row(4'b0000,0,0,0,            4'b0000,0,'0,4'b0001,32'h77777777, 105);

`ifdef CODE_ARB_TIMEOUT_EN
    // Silent memory: error response TMO cycles after the first WAIT cycle.
    begin
      int n;
      row(4'b0100,1,0,0, 4'b0100,0,'0,4'b0000,0, 200);
      row(4'b0000,1,0,0, 4'b0000,1,A2,4'b0000,0, 201);
      n = 0;
      while (n < 4*TMO) begin
        @(negedge clk);
        req_valid_i = '0;
        code_read_ready_i = 1'b0;
        #1;
        n++;
        if (rsp_valid_o != '0) break;
      end
      chk("timeout latency", 64'(n), 64'(TMO+1));
      chk("timeout rsp_valid", 64'(rsp_valid_o), 64'(4'b0100));
      chk("timeout rsp_err", 64'(rsp_err_o), 64'(1));
      chk("timeout rsp_data", 64'(rsp_data_o), 64'(0));
      // Next request: the first (late) beat is discarded, the second is delivered.
      row(4'b0001,1,0,0,            4'b0001,0,'0,4'b0000,0, 202);
      row(4'b0000,1,0,0,            4'b0000,1,A0,4'b0000,0, 203);
      row(4'b0000,1,1,32'hBAD00BAD, 4'b0000,0,'0,4'b0000,0, 204);
      row(4'b0000,1,0,0,            4'b0000,0,'0,4'b0000,0, 205);
      row(4'b0000,1,1,32'h12345678, 4'b0000,0,'0,4'b0000,0, 206);
      row(4'b0000,0,0,0,            4'b0000,0,'0,4'b0001,32'h12345678, 207);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
